// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: op encodings, CSR addresses and mstatus bit positions shared by the CSR file.
package csr_unit_pkg;

    typedef enum logic [2:0] {
        CSR_OP_NOP   = 3'd0,
        CSR_OP_RW    = 3'd1,
        CSR_OP_RS    = 3'd2,
        CSR_OP_RC    = 3'd3,
        CSR_OP_ECALL = 3'd4,
        CSR_OP_MRET  = 3'd5
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    localparam int ECALL_FROM_M = 11;

    function automatic logic is_csr_access(input csr_op_e op);
        return op == CSR_OP_RW || op == CSR_OP_RS || op == CSR_OP_RC;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter: 64-bit free-running counter; a write to either half replaces it and
// freezes the other half for that cycle, so no carry crosses a written low half.
module csr_counter
    import csr_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (wr_lo || wr_hi)
            count <= {wr_hi ? wdata_hi : count[63:32], wr_lo ? wdata_lo : count[31:0]};
        else
            count <= count + 64'd1;
    end

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with CSRRW/RS/RC, ECALL/MRET trap entry/return,
// masked mstatus, mscratch and mcycle; read data and redirect are combinational.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter bit          HAS_MSCRATCH = 1'b1,
    parameter bit          HAS_MCYCLE   = 1'b1,
    parameter logic [63:0] MTVEC_RESET  = 64'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    csr_op_e         op;
    logic            access, ecall, mret, legal, do_write;
    logic            mie, mpie;
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mscratch, cur, nv;
    logic [63:0]     cycle, nv64;

    assign op     = csr_op_e'(csr_op_i);
    assign access = valid_i && !reset && is_csr_access(op);
    assign ecall  = valid_i && !reset && op == CSR_OP_ECALL;
    assign mret   = valid_i && !reset && op == CSR_OP_MRET;

    always_comb begin
        mstatus = '0;
        mstatus[MSTATUS_MPP +: 2] = 2'b11;
        mstatus[MSTATUS_MPIE] = mpie;
        mstatus[MSTATUS_MIE] = mie;
    end

    always_comb begin
        legal = 1'b1;
        cur = '0;
        case (csr_addr_i)
            CSR_MSTATUS:  cur = mstatus;
            CSR_MTVEC:    cur = mtvec;
            CSR_MEPC:     cur = mepc;
            CSR_MCAUSE:   cur = mcause;
            CSR_MSCRATCH: begin
                legal = HAS_MSCRATCH;
                cur = mscratch;
            end
            CSR_MCYCLE: begin
                legal = HAS_MCYCLE;
                cur = cycle[XLEN-1:0];
            end
            CSR_MCYCLEH: begin
                legal = HAS_MCYCLE && XLEN == 32;
                cur = XLEN'(cycle[63:32]);
            end
            default:      legal = 1'b0;
        endcase
    end

    assign nv = op == CSR_OP_RW ? wdata_i : op == CSR_OP_RS ? cur | wdata_i : cur & ~wdata_i;
    assign do_write = access && legal && (op == CSR_OP_RW || wdata_i != '0);

    assign rdata_o       = access && legal ? cur : '0;
    assign illegal_o     = access && !legal;
    assign redirect_o    = ecall || mret;
    assign redirect_pc_o = ecall ? mtvec : mret ? mepc : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET[XLEN-1:0] & ALIGN_MASK;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
        end else if (ecall) begin
            mepc   <= pc_i & ALIGN_MASK;
            mcause <= XLEN'(ECALL_FROM_M);
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (do_write) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie  <= nv[MSTATUS_MIE];
                    mpie <= nv[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec <= nv & ALIGN_MASK;
                CSR_MEPC:     mepc <= nv & ALIGN_MASK;
                CSR_MCAUSE:   mcause <= nv;
                CSR_MSCRATCH: mscratch <= nv;
                default: ;
            endcase
        end
    end

    assign nv64 = 64'(nv);

    // On XLEN=64 the single mcycle address spans both counter halves.
    generate
        if (HAS_MCYCLE) begin : g_mcycle
            csr_counter u_counter (
                .clk      (clk),
                .reset    (reset),
                .wr_lo    (do_write && csr_addr_i == CSR_MCYCLE),
                .wr_hi    (do_write && csr_addr_i == (XLEN == 64 ? CSR_MCYCLE : CSR_MCYCLEH)),
                .wdata_lo (nv64[31:0]),
                .wdata_hi (XLEN == 64 ? nv64[63:32] : nv64[31:0]),
                .count    (cycle)
            );
        end else begin : g_no_mcycle
            assign cycle = '0;
        end
    endgenerate

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scoreboard bench for csr_unit (XLEN=32) plus a HAS_MSCRATCH=0 instance.
module tb_csr_unit;
    import csr_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  op = '0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0, pc = '0;
    logic [31:0] rdata, rpc, rdata2, rpc2;
    logic        ill, redir, ill2, redir2;
    int          errors = 0, checks = 0;
    logic [63:0] mc = '0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        il;
        logic        rr;
        logic [31:0] rp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .HAS_MSCRATCH(1'b1), .HAS_MCYCLE(1'b1), .MTVEC_RESET(64'h0)) dut (
        .clk(clk), .reset(reset), .valid_i(valid), .csr_op_i(op), .csr_addr_i(addr),
        .wdata_i(wdata), .pc_i(pc), .rdata_o(rdata), .illegal_o(ill),
        .redirect_o(redir), .redirect_pc_o(rpc)
    );

    csr_unit #(.XLEN(32), .HAS_MSCRATCH(1'b0), .HAS_MCYCLE(1'b1), .MTVEC_RESET(64'h0)) dut2 (
        .clk(clk), .reset(reset), .valid_i(valid), .csr_op_i(op), .csr_addr_i(addr),
        .wdata_i(wdata), .pc_i(pc), .rdata_o(rdata2), .illegal_o(ill2),
        .redirect_o(redir2), .redirect_pc_o(rpc2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock per step: drive after negedge, sample 2ns later, commit on the next posedge.
    task automatic step(input string tag, input logic rst, input logic [2:0] o, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] p, input logic [31:0] erd,
                        input logic eil, input logic err, input logic [31:0] erp);
        exp_t e;
        @(negedge clk);
        reset = rst;
        valid = o != 3'd0;
        op = o;
        addr = a;
        wdata = wd;
        pc = p;
        sb.push_back('{tag, erd, eil, err, erp});
        #2;
        e = sb.pop_front();
        chk({e.tag, ".rdata"}, rdata, e.rd);
        chk({e.tag, ".illegal"}, {31'b0, ill}, {31'b0, e.il});
        chk({e.tag, ".redirect"}, {31'b0, redir}, {31'b0, e.rr});
        chk({e.tag, ".redirect_pc"}, rpc, e.rp);
        if (rst)
            mc = '0;
        else if (o == 3'd1 && a == 12'hB00)
            mc[31:0] = wd;
        else if (o == 3'd1 && a == 12'hB80)
            mc[63:32] = wd;
        else
            mc = mc + 64'd1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        step(tag, 1'b0, 3'd2, a, 32'h0, 32'h0, exp, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr(input string tag, input logic [2:0] o, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] old);
        step(tag, 1'b0, o, a, wd, 32'h0, old, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        step("rst_read", 1'b1, 3'd2, 12'h300, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("rst_ecall", 1'b1, 3'd4, 12'h000, 32'h0, 32'h8000_0040, 32'h0, 1'b0, 1'b0, 32'h0);
        step("rst_ill", 1'b1, 3'd1, 12'h7C0, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rd("mcycle_first", 12'hB00, 32'h0);
        rd("mcycle_second", 12'hB00, 32'h1);
        rd("mstatus_rst", 12'h300, 32'h0000_1800);
        rd("mtvec_rst", 12'h305, 32'h0);
        rd("mepc_rst", 12'h341, 32'h0);
        rd("mcause_rst", 12'h342, 32'h0);
        rd("mscratch_rst", 12'h340, 32'h0);
        wr("rw_mtvec", 3'd1, 12'h305, 32'h8000_0103, 32'h0);
        rd("mtvec_new", 12'h305, 32'h8000_0100);
        wr("rs_mstatus", 3'd2, 12'h300, 32'h8, 32'h0000_1800);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        wr("rc_zero", 3'd3, 12'h300, 32'h0, 32'h0000_1808);
        rd("rc_zero_kept", 12'h300, 32'h0000_1808);
        wr("rc_mie", 3'd3, 12'h300, 32'h8, 32'h0000_1808);
        rd("mstatus_clr", 12'h300, 32'h0000_1800);
        wr("rw_mstatus_mask", 3'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800);
        rd("mstatus_masked", 12'h300, 32'h0000_1888);
        wr("rw_mstatus_mie", 3'd1, 12'h300, 32'h8, 32'h0000_1888);
        step("ecall", 1'b0, 3'd4, 12'h000, 32'h0, 32'h8000_0041, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
        chk("ecall.redirect_s2", {31'b0, redir2}, 32'h1);
        chk("ecall.redirect_pc_s2", rpc2, 32'h8000_0100);
        rd("mepc_trap", 12'h341, 32'h8000_0040);
        rd("mcause_trap", 12'h342, 32'd11);
        rd("mstatus_trap", 12'h300, 32'h0000_1880);
        step("mret", 1'b0, 3'd5, 12'h000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0040);
        rd("mstatus_mret", 12'h300, 32'h0000_1888);
        rd("nop_idle", 12'h342, 32'd11);
        wr("rw_mscratch", 3'd1, 12'h340, 32'hDEAD_BEEF, 32'h0);
        chk("mscratch_off.illegal", {31'b0, ill2}, 32'h1);
        chk("mscratch_off.rdata", rdata2, 32'h0);
        rd("mscratch_new", 12'h340, 32'hDEAD_BEEF);
        chk("mscratch_off.read_ill", {31'b0, ill2}, 32'h1);
        chk("mscratch_off.read_rdata", rdata2, 32'h0);
        step("ill_7c0", 1'b0, 3'd1, 12'h7C0, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step("ill_7c0_rs", 1'b0, 3'd2, 12'h7C0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        rd("after_ill_mstatus", 12'h300, 32'h0000_1888);
        rd("after_ill_mtvec", 12'h305, 32'h8000_0100);
        rd("after_ill_mepc", 12'h341, 32'h8000_0040);
        wr("rw_mcycle_lo", 3'd1, 12'hB00, 32'hFFFF_FFFF, mc[31:0]);
        rd("mcycle_lo_set", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_lo_wrap", 12'hB00, mc[31:0]);
        rd("mcycle_hi_carry", 12'hB80, mc[63:32]);
        chk("mcycle_hi_model", mc[63:32], 32'h1);
        wr("rw_mcycleh", 3'd1, 12'hB80, 32'h5, mc[63:32]);
        rd("mcycleh_new", 12'hB80, 32'h5);
        rd("mcycle_lo_run", 12'hB00, mc[31:0]);
        step("rst_mid_ecall", 1'b1, 3'd4, 12'h000, 32'h0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0);
        rd("mepc_after_rst", 12'h341, 32'h0);
        rd("mcause_after_rst", 12'h342, 32'h0);
        rd("mstatus_after_rst", 12'h300, 32'h0000_1800);
        rd("mtvec_after_rst", 12'h305, 32'h0);
        rd("mcycle_after_rst", 12'hB00, mc[31:0]);
        step("idle", 1'b0, 3'd0, 12'h300, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
